// File: rtl/gfx_move_scheduler.sv
// Purpose : arbitrates two game FSMs onto the shared sprite clear/draw engines; each move erases old 8x8 block then draws new.
// Latency : grant -> ack = 2 + clear BUSY cycles + 3 + draw BUSY cycles + 1 edges; VGA mux is combinational (zero latency).
// Backpr. : requests are level-held until ack; engines pace the move via done; a stuck engine aborts after TIMEOUT BUSY cycles.
//
// Ports:
//   clock, reset_n                  - clock, synchronous active-low reset
//   req*/old_*/new_*/col*           - per-requester move request, anchors and draw colour
//   ack0, ack1, err, busy           - completion pulse, abort flag (valid with ack), move in progress
//   clr_start, clr_ref*             - clear engine start pulse and anchor (old position)
//   clr_x/y/colour/writeEn/done     - clear engine pixel stream and completion
//   drw_start, drw_ref*, drw_colour - draw engine start pulse, anchor (new position) and colour
//   drw_x/y/colour_in/writeEn/done  - draw engine pixel stream and completion
//   vga_x/y/colour/writeEn          - muxed pixel stream to the VGA adapter
module gfx_move_scheduler #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  // requester 0 (player)
  input  logic       req0,
  input  logic [7:0] old_x0,
  input  logic [6:0] old_y0,
  input  logic [7:0] new_x0,
  input  logic [6:0] new_y0,
  input  logic [2:0] col0,
  // requester 1 (enemy / wave)
  input  logic       req1,
  input  logic [7:0] old_x1,
  input  logic [6:0] old_y1,
  input  logic [7:0] new_x1,
  input  logic [6:0] new_y1,
  input  logic [2:0] col1,
  // status
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic       busy,
  // clear engine
  output logic       clr_start,
  output logic [7:0] clr_refX,
  output logic [6:0] clr_refY,
  input  logic [7:0] clr_x,
  input  logic [6:0] clr_y,
  input  logic [2:0] clr_colour,
  input  logic       clr_writeEn,
  input  logic       clr_done,
  // draw engine
  output logic       drw_start,
  output logic [7:0] drw_refX,
  output logic [6:0] drw_refY,
  output logic [2:0] drw_colour,
  input  logic [7:0] drw_x,
  input  logic [6:0] drw_y,
  input  logic [2:0] drw_colour_in,
  input  logic       drw_writeEn,
  input  logic       drw_done,
  // VGA adapter write port
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_writeEn
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLR_START = 3'd1,
    S_CLR_SKIP  = 3'd2,
    S_CLR_BUSY  = 3'd3,
    S_DRW_START = 3'd4,
    S_DRW_SKIP  = 3'd5,
    S_DRW_BUSY  = 3'd6,
    S_ACK       = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic            rr_last_q, rr_last_d;    // requester granted most recently
  logic            grant_q, grant_d;        // requester owning the current move
  logic [7:0]      old_x_q, old_x_d;
  logic [6:0]      old_y_q, old_y_d;
  logic [7:0]      new_x_q, new_x_d;
  logic [6:0]      new_y_q, new_y_d;
  logic [2:0]      col_q, col_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            abort_q, abort_d;        // move aborted by an engine timeout
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            clr_start_q, clr_start_d;
  logic            drw_start_q, drw_start_d;

  logic            grant_sel;

  // Tie goes to whoever was not served last, so two held requests alternate.
  always_comb begin
    grant_sel = 1'b0;
    if (req0 && req1) begin
      grant_sel = ~rr_last_q;
    end else begin
      grant_sel = req1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    old_x_d   = old_x_q;
    old_y_d   = old_y_q;
    new_x_d   = new_x_q;
    new_y_d   = new_y_q;
    col_d     = col_q;
    timer_d   = timer_q;
    abort_d   = abort_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d   = grant_sel;
          rr_last_d = grant_sel;
          if (grant_sel) begin
            old_x_d = old_x1;
            old_y_d = old_y1;
            new_x_d = new_x1;
            new_y_d = new_y1;
            col_d   = col1;
          end else begin
            old_x_d = old_x0;
            old_y_d = old_y0;
            new_x_d = new_x0;
            new_y_d = new_y0;
            col_d   = col0;
          end
          abort_d = 1'b0;
          timer_d = '0;
          state_d = S_CLR_START;
        end
      end

      S_CLR_START: state_d = S_CLR_SKIP;

      // The engine's done is still high from its previous run here, so it is ignored.
      S_CLR_SKIP:  state_d = S_CLR_BUSY;

      S_CLR_BUSY: begin
        if (clr_done) begin
          timer_d = '0;
          state_d = S_DRW_START;
        end else if (timer_q == TW'(TIMEOUT)) begin
          abort_d = 1'b1;
          state_d = S_ACK;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DRW_START: state_d = S_DRW_SKIP;

      S_DRW_SKIP:  state_d = S_DRW_BUSY;

      S_DRW_BUSY: begin
        if (drw_done) begin
          state_d = S_ACK;
        end else if (timer_q == TW'(TIMEOUT)) begin
          abort_d = 1'b1;
          state_d = S_ACK;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_ACK: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered straight from the next state so they are glitch-free Moore outputs.
    busy_d      = (state_d != S_IDLE);
    clr_start_d = (state_d == S_CLR_START);
    drw_start_d = (state_d == S_DRW_START);
    ack0_d      = (state_d == S_ACK) && !grant_d;
    ack1_d      = (state_d == S_ACK) &&  grant_d;
    err_d       = (state_d == S_ACK) &&  abort_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      grant_q     <= 1'b0;
      old_x_q     <= '0;
      old_y_q     <= '0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      col_q       <= '0;
      timer_q     <= '0;
      abort_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      clr_start_q <= 1'b0;
      drw_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      grant_q     <= grant_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      col_q       <= col_d;
      timer_q     <= timer_d;
      abort_q     <= abort_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      clr_start_q <= clr_start_d;
      drw_start_q <= drw_start_d;
    end
  end

  // Pixel stream mux: whichever engine owns the current phase drives the VGA port.
  always_comb begin
    vga_x       = '0;
    vga_y       = '0;
    vga_colour  = '0;
    vga_writeEn = 1'b0;
    unique case (state_q)
      S_CLR_START, S_CLR_SKIP, S_CLR_BUSY: begin
        vga_x       = clr_x;
        vga_y       = clr_y;
        vga_colour  = clr_colour;
        vga_writeEn = clr_writeEn;
      end
      S_DRW_START, S_DRW_SKIP, S_DRW_BUSY: begin
        vga_x       = drw_x;
        vga_y       = drw_y;
        vga_colour  = drw_colour_in;
        vga_writeEn = drw_writeEn;
      end
      default: begin
        vga_writeEn = 1'b0;
      end
    endcase
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign clr_start  = clr_start_q;
  assign drw_start  = drw_start_q;
  assign clr_refX   = old_x_q;
  assign clr_refY   = old_y_q;
  assign drw_refX   = new_x_q;
  assign drw_refY   = new_y_q;
  assign drw_colour = col_q;

endmodule

// File: tb/tb_gfx_move_scheduler.sv
// Purpose : self-checking bench for gfx_move_scheduler with 64-pixel clear/draw engine models.
// Latency : checks grant->ack distance, pixel order and back-to-back gaps through a scoreboard.
// Backpr. : requests held until ack, dropped on the ack cycle; every wait is cycle-bounded.
module tb_gfx_move_scheduler;

  logic       clock;
  logic       reset_n;
  logic       req0, req1;
  logic [7:0] old_x0, new_x0, old_x1, new_x1;
  logic [6:0] old_y0, new_y0, old_y1, new_y1;
  logic [2:0] col0, col1;
  logic       ack0, ack1, err, busy;
  logic       clr_start, drw_start;
  logic [7:0] clr_refX, drw_refX;
  logic [6:0] clr_refY, drw_refY;
  logic [2:0] drw_colour;
  logic [7:0] clr_x, drw_x;
  logic [6:0] clr_y, drw_y;
  logic [2:0] clr_colour, drw_colour_in;
  logic       clr_writeEn, clr_done, drw_writeEn, drw_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_writeEn;

  gfx_move_scheduler #(.TIMEOUT(255), .TW(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .old_x0(old_x0), .old_y0(old_y0), .new_x0(new_x0), .new_y0(new_y0), .col0(col0),
    .req1(req1), .old_x1(old_x1), .old_y1(old_y1), .new_x1(new_x1), .new_y1(new_y1), .col1(col1),
    .ack0(ack0), .ack1(ack1), .err(err), .busy(busy),
    .clr_start(clr_start), .clr_refX(clr_refX), .clr_refY(clr_refY),
    .clr_x(clr_x), .clr_y(clr_y), .clr_colour(clr_colour), .clr_writeEn(clr_writeEn), .clr_done(clr_done),
    .drw_start(drw_start), .drw_refX(drw_refX), .drw_refY(drw_refY), .drw_colour(drw_colour),
    .drw_x(drw_x), .drw_y(drw_y), .drw_colour_in(drw_colour_in), .drw_writeEn(drw_writeEn), .drw_done(drw_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_writeEn(vga_writeEn)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- engine models: start seen, 1 cycle later done falls, 64 writes, then done ----------------
  logic       clr_stuck;
  logic       clr_pend, clr_run, drw_pend, drw_run;
  int         clr_cnt, drw_cnt;
  logic [7:0] clr_ax, drw_ax;
  logic [6:0] clr_ay, drw_ay;
  logic [2:0] drw_c;

  assign clr_colour = 3'b000;

  always @(posedge clock) begin
    if (!reset_n) begin
      clr_done <= 1'b1; clr_writeEn <= 1'b0; clr_pend <= 1'b0; clr_run <= 1'b0;
      clr_x <= '0; clr_y <= '0; clr_cnt <= 0; clr_ax <= '0; clr_ay <= '0;
    end else begin
      clr_pend <= 1'b0;
      if (clr_start) begin
        clr_pend <= 1'b1; clr_ax <= clr_refX; clr_ay <= clr_refY;
      end
      if (clr_pend) begin
        clr_done <= 1'b0;
        if (!clr_stuck) begin
          clr_writeEn <= 1'b1; clr_x <= clr_ax; clr_y <= clr_ay; clr_cnt <= 1; clr_run <= 1'b1;
        end
      end else if (clr_run) begin
        if (clr_cnt == 64) begin
          clr_writeEn <= 1'b0; clr_done <= 1'b1; clr_run <= 1'b0;
        end else begin
          clr_x <= clr_ax + 8'(clr_cnt % 8); clr_y <= clr_ay - 7'(clr_cnt / 8); clr_cnt <= clr_cnt + 1;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      drw_done <= 1'b1; drw_writeEn <= 1'b0; drw_pend <= 1'b0; drw_run <= 1'b0;
      drw_x <= '0; drw_y <= '0; drw_colour_in <= '0; drw_cnt <= 0; drw_ax <= '0; drw_ay <= '0; drw_c <= '0;
    end else begin
      drw_pend <= 1'b0;
      if (drw_start) begin
        drw_pend <= 1'b1; drw_ax <= drw_refX; drw_ay <= drw_refY; drw_c <= drw_colour;
      end
      if (drw_pend) begin
        drw_done <= 1'b0; drw_writeEn <= 1'b1; drw_x <= drw_ax; drw_y <= drw_ay;
        drw_colour_in <= drw_c; drw_cnt <= 1; drw_run <= 1'b1;
      end else if (drw_run) begin
        if (drw_cnt == 64) begin
          drw_writeEn <= 1'b0; drw_done <= 1'b1; drw_run <= 1'b0;
        end else begin
          drw_x <= drw_ax + 8'(drw_cnt % 8); drw_y <= drw_ay - 7'(drw_cnt / 8); drw_cnt <= drw_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int id;
    int err;
    int lat;   // grant->ack distance in cycles, -1 = not checked
  } ack_exp_t;

  int       pixq[$];
  ack_exp_t ackq[$];
  int       gapq[$];
  int       start_cyc    = 0;
  int       last_ack_cyc = 0;
  int       drw_starts   = 0;

  function automatic int pix(input int x, input int y, input int c);
    return ((x & 255) << 10) | ((y & 127) << 3) | (c & 7);
  endfunction

  // One full move: 64 clear writes (colour 0) at the old anchor, then 64 draws at the new anchor.
  task automatic push_move(input int id, input int ox, input int oy, input int nx, input int ny, input int c);
    ack_exp_t e;
    for (int i = 0; i < 64; i++) pixq.push_back(pix(ox + i % 8, oy - i / 8, 0));
    for (int i = 0; i < 64; i++) pixq.push_back(pix(nx + i % 8, ny - i / 8, c));
    e.id = id; e.err = 0; e.lat = 134;
    ackq.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (vga_writeEn) begin
        if (pixq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d with no write expected", vga_x, vga_y, vga_colour);
        end else begin
          chk("pixel", pix(int'(vga_x), int'(vga_y), int'(vga_colour)), pixq.pop_front());
        end
      end
      if (clr_start) begin
        start_cyc = cyc;
        if (gapq.size() != 0) chk("b2b_gap", cyc - last_ack_cyc, gapq.pop_front());
      end
      if (drw_start) drw_starts++;
      if (err && !(ack0 || ack1)) begin
        n_checks++; n_fail++;
        $display("FAIL err_without_ack: got err=1 required err=0");
      end
      if (ack0 || ack1) begin
        last_ack_cyc = cyc;
        chk("ack_both", int'(ack0 & ack1), 0);
        if (ackq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ack_unexpected: got ack0=%0d ack1=%0d with no ack expected", ack0, ack1);
        end else begin
          ack_exp_t e;
          e = ackq.pop_front();
          chk("ack_id", ack1 ? 1 : 0, e.id);
          chk("ack_err", int'(err), e.err);
          if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ack(input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (ack0 || ack1) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got no ack within %0d cycles, required ack", name, budget);
    end
  endtask

  initial begin
    int d0;
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; clr_stuck = 1'b0;
    old_x0 = 8'd10; old_y0 = 7'd50; new_x0 = 8'd11; new_y0 = 7'd50; col0 = 3'b100;
    old_x1 = 8'd40; old_y1 = 7'd20; new_x1 = 8'd41; new_y1 = 7'd21; col1 = 3'b011;
    repeat (3) @(negedge clock);
    // reset values
    chk("rst_busy", busy, 0);        chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);        chk("rst_err", err, 0);
    chk("rst_clr_start", clr_start, 0); chk("rst_drw_start", drw_start, 0);
    chk("rst_vga_we", vga_writeEn, 0);  chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);      chk("rst_vga_col", vga_colour, 0);
    reset_n = 1'b1;

    // idle with no requests
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle_quiet", {busy, vga_writeEn, ack0, ack1}, 0);
    end

    // simultaneous requests held for four moves: order 0,1,0,1 with one IDLE cycle between moves
    push_move(0, 10, 50, 11, 50, 3'b100);
    push_move(1, 40, 20, 41, 21, 3'b011);
    push_move(0, 10, 50, 11, 50, 3'b100);
    push_move(1, 40, 20, 41, 21, 3'b011);
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(400, "tie_ack1");
    gapq.push_back(2); gapq.push_back(2); gapq.push_back(2);
    wait_ack(400, "tie_ack2");
    wait_ack(400, "tie_ack3");
    wait_ack(400, "tie_ack4");
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clock);
    chk("tie_idle_busy", busy, 0);

    // single player move: clear (10..17, 50..43) then draw (11..18, 50..43) colour 100
    push_move(0, 10, 50, 11, 50, 3'b100);
    req0 = 1'b1;
    wait_ack(400, "single_ack");
    req0 = 1'b0;
    repeat (3) @(negedge clock);

    // clear engine never finishes: abort with err and no draw phase
    begin
      ack_exp_t e;
      e.id = 0; e.err = 1; e.lat = -1;
      ackq.push_back(e);
    end
    clr_stuck = 1'b1;
    old_x0 = 8'd30; old_y0 = 7'd30; new_x0 = 8'd31; new_y0 = 7'd30; col0 = 3'b010;
    d0 = drw_starts;
    req0 = 1'b1;
    wait_ack(600, "timeout_ack");
    req0 = 1'b0;
    clr_stuck = 1'b0;
    repeat (3) @(negedge clock);
    chk("timeout_no_drw_start", drw_starts, d0);
    chk("timeout_idle_busy", busy, 0);

    // reset in the middle of the clear phase
    old_x0 = 8'd100; old_y0 = 7'd60; new_x0 = 8'd101; new_y0 = 7'd61; col0 = 3'b111;
    push_move(0, 100, 60, 101, 61, 3'b111);
    req0 = 1'b1;
    repeat (30) @(negedge clock);
    chk("mid_busy_before_rst", busy, 1);
    reset_n = 1'b0; req0 = 1'b0;
    @(negedge clock);
    pixq.delete(); ackq.delete();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vga_we", vga_writeEn, 0);
    chk("mid_rst_ack0", ack0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("post_rst_quiet", {busy, vga_writeEn, ack0, ack1}, 0);
    end

    // enemy move after the reset completes normally
    push_move(1, 40, 20, 41, 21, 3'b011);
    req1 = 1'b1;
    wait_ack(400, "post_rst_ack1");
    req1 = 1'b0;
    repeat (5) @(negedge clock);

    chk("pixq_drained", pixq.size(), 0);
    chk("ackq_drained", ackq.size(), 0);
    chk("gapq_drained", gapq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
